// File: rtl/ac3_ctrl_pkg.sv
// Shared types and width helpers for the AC3 output-register sequencer.
package ac3_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SHIFT,
    DONE,
    ABORT_CLR
  } state_e;

  // Width of one AC3 output register: accumulation tree growth plus product width
  // plus headroom for the maximum number of operations per output.
  function automatic int ac3_width(input int m, input int pa, input int pw, input int mno);
    return $clog2(m) + pa + pw + $clog2(mno);
  endfunction

  // Bits needed to hold any shift amount from 0 to w-1.
  function automatic int ac3_shw(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/ac3_shift_cnt.sv
// Per-lane quantization shift counter: loads a clamped amount, counts down while
// the sequencer is in SHIFT and requests one arithmetic shift per nonzero count.
module ac3_shift_cnt #(
  parameter int W   = 29,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           run,
  input  logic [SHW-1:0] amt_in,
  output logic           s_en,
  output logic           last
);

  logic [SHW-1:0] amt_clamp;
  logic [SHW-1:0] cnt_q, cnt_d;

  // Shifting by W or more is meaningless on a W-bit register; cap at W-1.
  always_comb begin
    amt_clamp = amt_in;
    if (int'(amt_in) > W - 1) amt_clamp = SHW'(W - 1);
  end

  // Load on SHIFT entry, count down while running, park at zero otherwise
  // so an aborted frame cannot leak shifts into the next one.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = amt_clamp;
    else if (!run)           cnt_d = '0;
    else if (cnt_q != '0)    cnt_d = cnt_q - SHW'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign s_en = run && (cnt_q != '0);
  // This lane finishes shifting on the current cycle (or has nothing to do).
  assign last = (cnt_q <= SHW'(1));

endmodule

// File: rtl/ac3_quant_ctrl.sv
// Sequencer for the AC3 output register bank: clear, accumulate writes, then
// quantize each lane by its own arithmetic right-shift amount, and signal done.
module ac3_quant_ctrl
  import ac3_ctrl_pkg::*;
#(
  parameter  int NREG = 4,
  parameter  int M    = 16,
  parameter  int Pa   = 8,
  parameter  int Pw   = 8,
  parameter  int MNO  = 288,
  localparam int W    = ac3_width(M, Pa, Pw, MNO),
  localparam int SHW  = ac3_shw(W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NREG*SHW-1:0] shamt_in,
  input  logic                wr_valid,
  input  logic                wr_last,
  input  logic                abort,
  output logic [NREG-1:0]     cl_en,
  output logic [NREG-1:0]     w_en,
  output logic [NREG-1:0]     s_en,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [NREG-1:0]     cl_en_q, cl_en_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [NREG*SHW-1:0] shamt_q, shamt_d;
  logic [NREG-1:0]     lane_last;
  logic                cnt_load, cnt_run;

  // Next-state logic; abort wins over write completion and shift completion.
  always_comb begin
    state_d = state_q;
    shamt_d = shamt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        shamt_d = shamt_in;
      end
      CLEAR:     state_d = abort ? ABORT_CLR : ACCUM;
      ACCUM: begin
        if (abort)                    state_d = ABORT_CLR;
        else if (wr_valid && wr_last) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)           state_d = ABORT_CLR;
        else if (&lane_last) state_d = DONE;
      end
      DONE:      state_d = abort ? ABORT_CLR : IDLE;
      ABORT_CLR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    cl_en_d = (state_d == CLEAR || state_d == ABORT_CLR) ? {NREG{1'b1}} : '0;
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // FSM state, shift-amount latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shamt_q <= '0;
      cl_en_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shamt_q <= shamt_d;
      cl_en_q <= cl_en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign cnt_run  = (state_q == SHIFT);
  assign cnt_load = (state_q == ACCUM) && (state_d == SHIFT);

  for (genvar i = 0; i < NREG; i++) begin : g_lane
    ac3_shift_cnt #(.W(W), .SHW(SHW)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load   (cnt_load),
      .run    (cnt_run),
      .amt_in (shamt_q[i*SHW +: SHW]),
      .s_en   (s_en[i]),
      .last   (lane_last[i])
    );
  end

  // Writes follow the datapath directly so the final write lands the same cycle as wr_last.
  assign w_en  = {NREG{(state_q == ACCUM) && wr_valid}};
  assign cl_en = cl_en_q;
  assign done  = done_q;
  assign busy  = busy_q;

  // A lane register must never see two operations in the same cycle.
  a_excl: assert property (@(posedge clk) disable iff (rst)
    ((cl_en & w_en) | (cl_en & s_en) | (w_en & s_en)) == '0);

endmodule
